// File: rtl/greedysnake_dpb_w.sv
// Snake position-list writer on DPB channel A: advances the head each tick and,
// on growth, opens a slot after the head by shifting the upper entries up one.
module greedysnake_dpb_w #(
    parameter logic [10:0] ADDRESS_STEP_N     = 11'd4,
    parameter logic [10:0] DATA_BEGIN_ADDRESS = 11'd4,
    parameter logic [3:0]  READ_LAT           = 4'd2,
    parameter logic [10:0] MAX_LEN            = 11'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [1:0]  dir,
    input  logic        grow,
    input  logic        halt,
    output logic        busy,
    output logic        done,
    output logic [10:0] list_length,
    output logic [10:0] list_head_addr,
    output logic [7:0]  head_pos,
    output logic        i_a_clk_en,
    output logic        i_a_data_en,
    output logic        i_a_wr_en,
    output logic [7:0]  i_a_data,
    output logic [10:0] i_a_address,
    input  logic [7:0]  o_a_data
);

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CALC,
        S_SHIFT_RD,
        S_SHIFT_WR,
        S_WR_HEAD,
        S_FINISH
    } state_t;

    state_t          state;
    logic [1:0]      cur_dir;
    logic            grow_r;
    logic [DW-1:0]   new_pos;
    logic [AW-1:0]   j_addr;
    logic [3:0]      wait_cnt;
    logic [DW-1:0]   rd_data;
    logic [1:0]      init_cnt;

    logic [AW-1:0]   last_addr_c;
    logic [AW-1:0]   next_head_c;
    logic [1:0]      eff_dir_c;
    logic [DW-1:0]   step_pos_c;

    assign i_a_clk_en  = 1'b1;
    assign i_a_data_en = 1'b1;

    assign last_addr_c = DATA_BEGIN_ADDRESS + AW'((list_length - 11'd1) * ADDRESS_STEP_N);
    assign next_head_c = (grow_r || (list_head_addr != last_addr_c))
                         ? AW'(list_head_addr + ADDRESS_STEP_N) : DATA_BEGIN_ADDRESS;

    // A direct reversal would drive the head into its own neck, so it is dropped.
    assign eff_dir_c = (dir == (cur_dir ^ 2'b01)) ? cur_dir : dir;

    // Each nibble wraps on its own; no carry between x and y.
    always_comb begin
        step_pos_c = head_pos;
        case (eff_dir_c)
            2'd0:    step_pos_c[3:0] = head_pos[3:0] - 4'd1;
            2'd1:    step_pos_c[3:0] = head_pos[3:0] + 4'd1;
            2'd2:    step_pos_c[7:4] = head_pos[7:4] - 4'd1;
            default: step_pos_c[7:4] = head_pos[7:4] + 4'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_INIT;
            busy           <= 1'b1;
            done           <= 1'b0;
            i_a_wr_en      <= 1'b0;
            i_a_data       <= '0;
            i_a_address    <= DATA_BEGIN_ADDRESS;
            cur_dir        <= 2'd3;
            list_length    <= 11'd3;
            list_head_addr <= DATA_BEGIN_ADDRESS + AW'(ADDRESS_STEP_N * 11'd2);
            head_pos       <= 8'h48;
            grow_r         <= 1'b0;
            new_pos        <= '0;
            j_addr         <= '0;
            wait_cnt       <= '0;
            rd_data        <= '0;
            init_cnt       <= '0;
        end else begin
            i_a_wr_en <= 1'b0;
            i_a_data  <= '0;
            done      <= 1'b0;
            case (state)
                S_INIT: begin
                    i_a_wr_en   <= 1'b1;
                    i_a_address <= DATA_BEGIN_ADDRESS + AW'(AW'(init_cnt) * ADDRESS_STEP_N);
                    i_a_data    <= {4'(4'd2 + 4'(init_cnt)), 4'h8};
                    if (init_cnt == 2'd2) begin
                        init_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                S_IDLE: begin
                    if (step_en && !halt) begin
                        busy   <= 1'b1;
                        grow_r <= grow && (list_length < MAX_LEN);
                        state  <= S_CALC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_CALC: begin
                    cur_dir <= eff_dir_c;
                    new_pos <= step_pos_c;
                    if (grow_r && (list_head_addr != last_addr_c)) begin
                        j_addr   <= last_addr_c;
                        wait_cnt <= '0;
                        state    <= S_SHIFT_RD;
                    end else begin
                        state <= S_WR_HEAD;
                    end
                end
                S_SHIFT_RD: begin
                    if (wait_cnt == 4'd0) begin
                        i_a_address <= j_addr;
                    end
                    if (wait_cnt == READ_LAT) begin
                        rd_data <= o_a_data;
                        state   <= S_SHIFT_WR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_SHIFT_WR: begin
                    i_a_wr_en   <= 1'b1;
                    i_a_address <= AW'(j_addr + ADDRESS_STEP_N);
                    i_a_data    <= rd_data;
                    if (j_addr == AW'(list_head_addr + ADDRESS_STEP_N)) begin
                        state <= S_WR_HEAD;
                    end else begin
                        j_addr   <= AW'(j_addr - ADDRESS_STEP_N);
                        wait_cnt <= '0;
                        state    <= S_SHIFT_RD;
                    end
                end
                S_WR_HEAD: begin
                    // Length and head move together so the reader never sees a torn pair.
                    i_a_wr_en      <= 1'b1;
                    i_a_address    <= next_head_c;
                    i_a_data       <= new_pos;
                    list_head_addr <= next_head_c;
                    head_pos       <= new_pos;
                    if (grow_r) begin
                        list_length <= list_length + 11'd1;
                    end
                    done  <= 1'b1;
                    state <= S_FINISH;
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_greedysnake_dpb_w.sv
// Scoreboard bench for greedysnake_dpb_w: a slot-indexed snake model predicts every
// channel-A write plus the published length/head after each tick.
module tb_greedysnake_dpb_w;

    localparam int STEP = 4;
    localparam int BASE = 4;
    localparam int MAXL = 256;

    logic        clk = 1'b0;
    logic        rst, step_en, grow, halt;
    logic [1:0]  dir;
    logic        busy, done, i_a_clk_en, i_a_data_en, i_a_wr_en;
    logic [10:0] list_length, list_head_addr, i_a_address;
    logic [7:0]  head_pos, i_a_data, o_a_data;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [18:0] wq[$];
    logic [7:0]  dpb [0:2047];
    logic [7:0]  m_mem [0:MAXL-1];
    int          m_len, m_hidx;
    logic [1:0]  m_dir;
    logic [7:0]  m_pos;

    always #5 clk = ~clk;

    greedysnake_dpb_w dut (
        .clk            (clk),
        .rst            (rst),
        .step_en        (step_en),
        .dir            (dir),
        .grow           (grow),
        .halt           (halt),
        .busy           (busy),
        .done           (done),
        .list_length    (list_length),
        .list_head_addr (list_head_addr),
        .head_pos       (head_pos),
        .i_a_clk_en     (i_a_clk_en),
        .i_a_data_en    (i_a_data_en),
        .i_a_wr_en      (i_a_wr_en),
        .i_a_data       (i_a_data),
        .i_a_address    (i_a_address),
        .o_a_data       (o_a_data)
    );

    // DPB channel A: write-through array, registered read data.
    always @(posedge clk) begin
        if (i_a_wr_en) dpb[i_a_address] <= i_a_data;
        o_a_data <= dpb[i_a_address];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (i_a_wr_en) begin
            if (wq.size() == 0) check_eq("wr_pending", 32'(wq.size()), 32'd1);
            else check_eq("wr", 32'({i_a_address, i_a_data}), 32'(wq.pop_front()));
        end else begin
            check_eq("idle_data", 32'(i_a_data), 32'd0);
        end
    end

    function automatic logic [10:0] slot_addr(input int k);
        return 11'(BASE + k * STEP);
    endfunction

    task automatic model_reset();
        m_len = 3; m_hidx = 2; m_dir = 2'd3; m_pos = 8'h48;
        m_mem[0] = 8'h28; m_mem[1] = 8'h38; m_mem[2] = 8'h48;
        wq.delete();
        for (int k = 0; k < 3; k++) wq.push_back({slot_addr(k), m_mem[k]});
    endtask

    task automatic model_step(input logic [1:0] d, input logic g, output int cyc);
        logic [3:0] x, y;
        logic       opp;
        int         last;
        opp = (m_dir[1] == d[1]) && (m_dir[0] != d[0]);
        if (!opp) m_dir = d;
        x = m_pos[7:4];
        y = m_pos[3:0];
        case (m_dir)
            2'd0:    y = y - 4'd1;
            2'd1:    y = y + 4'd1;
            2'd2:    x = x - 4'd1;
            default: x = x + 4'd1;
        endcase
        m_pos = {x, y};
        last = m_len - 1;
        cyc = 4;
        if (g && m_len < MAXL) begin
            for (int k = last; k > m_hidx; k--) begin
                m_mem[k+1] = m_mem[k];
                wq.push_back({slot_addr(k + 1), m_mem[k]});
                cyc += 4;
            end
            m_len++;
            m_hidx++;
        end else begin
            m_hidx = (m_hidx == last) ? 0 : m_hidx + 1;
        end
        m_mem[m_hidx] = m_pos;
        wq.push_back({slot_addr(m_hidx), m_pos});
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_wq"},   32'(wq.size()), 32'd0);
        check_eq({tag, "_len"},  32'(list_length), 32'(m_len));
        check_eq({tag, "_head"}, 32'(list_head_addr), 32'(slot_addr(m_hidx)));
        check_eq({tag, "_pos"},  32'(head_pos), 32'(m_pos));
    endtask

    task automatic do_step(input string tag, input logic [1:0] d, input logic g);
        int exp_cyc, cyc, done_at, low_at, dc0;
        model_step(d, g, exp_cyc);
        @(negedge clk);
        step_en = 1'b1; dir = d; grow = g; halt = 1'b0;
        dc0 = done_cnt;
        @(negedge clk);
        step_en = 1'b0;
        cyc = 1; done_at = -1; low_at = -1;
        while (low_at < 0 && cyc < 3000) begin
            if (done && done_at < 0) begin
                done_at = cyc;
                check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            end
            if (!busy) low_at = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq({tag, "_done_cyc"}, 32'(done_at), 32'(exp_cyc - 1));
        check_eq({tag, "_busy_cyc"}, 32'(low_at), 32'(exp_cyc));
        check_eq({tag, "_done_n"},   32'(done_cnt - dc0), 32'd1);
        check_state(tag);
    endtask

    initial begin
        int busy_seen, dc0;
        for (int a = 0; a < 2048; a++) dpb[a] = 8'h00;
        rst = 1'b1; step_en = 1'b0; dir = 2'd3; grow = 1'b0; halt = 1'b0;
        wq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_wr",   32'(i_a_wr_en), 32'd0);
        check_eq("rst_len",  32'(list_length), 32'd3);
        check_eq("rst_head", 32'(list_head_addr), 32'd12);
        check_eq("rst_pos",  32'(head_pos), 32'h48);
        check_eq("rst_ce",   32'({i_a_clk_en, i_a_data_en}), 32'd3);

        model_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_state("init");
        check_eq("init_busy",  32'(busy), 32'd0);
        check_eq("init_ndone", 32'(done_cnt), 32'd0);

        do_step("reverse", 2'd2, 1'b0);
        check_eq("reverse_lit", 32'({list_head_addr, head_pos}), 32'({11'd4, 8'h58}));
        do_step("grow_shift", 2'd3, 1'b1);
        check_eq("grow_shift_lit", 32'({list_length, list_head_addr}), 32'({11'd4, 11'd8}));

        // Abort a growth mid-shift; INIT must rebuild the 3-entry snake.
        @(negedge clk);
        step_en = 1'b1; dir = 2'd3; grow = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
        @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1; grow = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_len", 32'(list_length), 32'd3);
        model_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_state("reinit");

        for (int i = 0; i < 12; i++) do_step("right", 2'd3, 1'b0);
        check_eq("x_wrap", 32'(head_pos), 32'h08);
        for (int i = 0; i < 9; i++) do_step("up", 2'd0, 1'b0);
        check_eq("y_wrap", 32'(head_pos), 32'h0F);

        while (m_hidx != m_len - 1) do_step("align", 2'd0, 1'b0);
        do_step("grow_last", 2'd0, 1'b1);
        while (m_len < MAXL) do_step("grow_fill", 2'd0, 1'b1);
        do_step("grow_max", 2'd0, 1'b1);
        check_eq("max_len",  32'(list_length), 32'd256);
        check_eq("max_wrap", 32'(list_head_addr), 32'd4);

        busy_seen = 0;
        dc0 = done_cnt;
        @(negedge clk);
        step_en = 1'b1; halt = 1'b1; dir = 2'd0; grow = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        halt = 1'b0; grow = 1'b0;
        check_eq("halt_busy", 32'(busy_seen), 32'd0);
        check_eq("halt_done", 32'(done_cnt - dc0), 32'd0);
        check_state("halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
